// File: rtl/backdoor_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : backdoor_scheduler                                                |
// | Purpose: Gives a Wishbone host access to the backdoor ports of the ROM/RAM |
// |          chips sharing the 4-bit bus. The CPU and bus chips are frozen via |
// |          halt at an instruction-cycle boundary, one access is forwarded    |
// |          to the selected target, and halt is released after an idle window.|
// | Ports  : clk_i, rst_ni (async, active-low)                                 |
// |          sync_i            CPU end-of-instruction-cycle pulse              |
// |          halt_o, busy_o    freeze request (registered) / non-idle flag     |
// |          wb_*_i / wb_*_o   host Wishbone slave side                        |
// |          t_cyc_o (one-hot), t_stb_o, t_we_o, t_addr_o, t_data_o           |
// |          t_data_i (32 bits per target), t_ack_i (per target)              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module backdoor_scheduler #(
  parameter int NUM_TARGETS = 7,
  parameter int SEL_LSB     = 24,
  parameter int SYNC_WAIT   = 16,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 15,
  parameter int LINGER      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sync_i,
  output logic                      halt_o,
  output logic                      busy_o,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [31:0]               wb_addr_i,
  input  logic [31:0]               wb_data_i,
  output logic [31:0]               wb_data_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic [NUM_TARGETS-1:0]    t_cyc_o,
  output logic                      t_stb_o,
  output logic                      t_we_o,
  output logic [31:0]               t_addr_o,
  output logic [31:0]               t_data_o,
  input  logic [32*NUM_TARGETS-1:0] t_data_i,
  input  logic [NUM_TARGETS-1:0]    t_ack_i
);

  // One shared counter serves every timed state; size it for the longest wait.
  localparam int MAX_A   = (SYNC_WAIT > TIMEOUT) ? SYNC_WAIT : TIMEOUT;
  localparam int MAX_B   = (LINGER > SETTLE) ? LINGER : SETTLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINGER_LAST = CNT_W'(LINGER - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_ACCESS    = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;
  localparam logic [2:0] ST_LINGER    = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   we_q, we_d;
  logic [2:0]             sel_q, sel_d;
  logic                   halt_q, halt_d;
  logic                   wb_ack_q, wb_ack_d;
  logic                   wb_err_q, wb_err_d;
  logic [31:0]            wb_data_q, wb_data_d;
  logic [NUM_TARGETS-1:0] t_cyc_q, t_cyc_d;
  logic                   t_stb_q, t_stb_d;

  logic                   req;
  logic                   sel_ok_q, sel_ok_d;
  logic                   ack_hit;
  logic                   resp_ok, resp_err;
  logic [31:0]            rdata;
  logic [NUM_TARGETS-1:0] onehot_d;

  // Requests are only taken while no access is outstanding.
  assign req = wb_cyc_i & wb_stb_i & ((state_q == ST_IDLE) | (state_q == ST_LINGER));

  assign sel_ok_q = ({29'd0, sel_q} < 32'(NUM_TARGETS));
  assign sel_ok_d = ({29'd0, sel_d} < 32'(NUM_TARGETS));

  // Decode from the next-cycle select so a LINGER->ACCESS shortcut drives the
  // freshly accepted target on its first ACCESS cycle.
  for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_onehot
    assign onehot_d[k] = (sel_d == 3'(k));
  end

  // t_cyc_q is the live one-hot target select during ACCESS, so it directly
  // gates which ack and which read slice are honoured.
  assign ack_hit = |(t_ack_i & t_cyc_q);

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (t_cyc_q[k]) rdata = rdata | t_data_i[32*k +: 32];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      halt_q    <= 1'b0;
      wb_ack_q  <= 1'b0;
      wb_err_q  <= 1'b0;
      wb_data_q <= '0;
      t_cyc_q   <= '0;
      t_stb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      halt_q    <= halt_d;
      wb_ack_q  <= wb_ack_d;
      wb_err_q  <= wb_err_d;
      wb_data_q <= wb_data_d;
      t_cyc_q   <= t_cyc_d;
      t_stb_q   <= t_stb_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    sel_d    = sel_q;
    resp_ok  = 1'b0;
    resp_err = 1'b0;

    if (req) begin
      addr_d = wb_addr_i;
      data_d = wb_data_i;
      we_d   = wb_we_i;
      sel_d  = wb_addr_i[SEL_LSB+2:SEL_LSB];
    end

    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        // Giving up on sync after SYNC_WAIT cycles covers a CPU held in reset.
        if (!wb_cyc_i)                              state_d = ST_IDLE;
        else if (sync_i || (cnt_q == SYNC_LAST))    state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!wb_cyc_i)                  state_d = ST_LINGER;
        else if (cnt_q == SETTLE_LAST)  state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = ST_LINGER;
        end else if (!sel_ok_q) begin
          state_d  = ST_RESP;
          resp_err = 1'b1;
        end else if (ack_hit) begin
          state_d = ST_RESP;
          resp_ok = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = ST_RESP;
          resp_err = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_LINGER;
      end
      ST_LINGER: begin
        if (req)                        state_d = ST_ACCESS;
        else if (cnt_q == LINGER_LAST)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter restarts on every state change and saturates otherwise.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
  end

  // Output logic (values registered on the edge entering the next state)
  always_comb begin
    halt_d    = (state_d == ST_SETTLE) || (state_d == ST_ACCESS) ||
                (state_d == ST_RESP)   || (state_d == ST_LINGER);
    t_cyc_d   = (state_d == ST_ACCESS) ? onehot_d : '0;
    t_stb_d   = (state_d == ST_ACCESS) && sel_ok_d;
    wb_ack_d  = resp_ok;
    wb_err_d  = resp_err;
    wb_data_d = wb_data_q;
    if (resp_ok)       wb_data_d = we_q ? 32'd0 : rdata;
    else if (resp_err) wb_data_d = 32'd0;
  end

  assign halt_o    = halt_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign wb_ack_o  = wb_ack_q;
  assign wb_err_o  = wb_err_q;
  assign wb_data_o = wb_data_q;
  assign t_cyc_o   = t_cyc_q;
  assign t_stb_o   = t_stb_q;
  assign t_we_o    = we_q;
  assign t_addr_o  = addr_q;
  assign t_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_backdoor_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_backdoor_scheduler                                             |
// | Purpose: Directed self-checking bench for backdoor_scheduler.              |
// |          Cycle cN = the cycle starting at the Nth rising edge after the    |
// |          request is driven; inputs are applied and outputs sampled 1 time  |
// |          unit after that edge.                                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_backdoor_scheduler;

  localparam int NT = 7;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          sync_i;
  logic          halt_o;
  logic          busy_o;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]   wb_addr_i, wb_data_i;
  logic [31:0]   wb_data_o;
  logic          wb_ack_o, wb_err_o;
  logic [NT-1:0] t_cyc_o;
  logic          t_stb_o, t_we_o;
  logic [31:0]   t_addr_o, t_data_o;
  logic [32*NT-1:0] t_data_i;
  logic [NT-1:0] t_ack_i;

  int n_cmp  = 0;
  int n_fail = 0;

  backdoor_scheduler dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sync_i    (sync_i),
    .halt_o    (halt_o),
    .busy_o    (busy_o),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_data_o (wb_data_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .t_cyc_o   (t_cyc_o),
    .t_stb_o   (t_stb_o),
    .t_we_o    (t_we_o),
    .t_addr_o  (t_addr_o),
    .t_data_o  (t_data_o),
    .t_data_i  (t_data_i),
    .t_ack_i   (t_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [31:0] d);
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  task automatic drop();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    sync_i    = 1'b0;
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    wb_we_i   = 1'b0;
    wb_addr_i = '0;
    wb_data_i = '0;
    t_data_i  = '0;
    t_ack_i   = '0;
    t_data_i[32*2 +: 32] = 32'hA5A5_0003;
    t_data_i[32*3 +: 32] = 32'h3333_3333;

    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Reset state
    chk("rst_halt",  32'(halt_o),    32'd0);
    chk("rst_busy",  32'(busy_o),    32'd0);
    chk("rst_ack",   32'(wb_ack_o),  32'd0);
    chk("rst_err",   32'(wb_err_o),  32'd0);
    chk("rst_tcyc",  32'(t_cyc_o),   32'd0);
    chk("rst_tstb",  32'(t_stb_o),   32'd0);
    chk("rst_wdat",  wb_data_o,      32'd0);
    chk("rst_taddr", t_addr_o,       32'd0);

    // ---- 1: read target 2, sync at c3 ----
    req(32'h0200_0010, 1'b0, 32'd0);                       // c0
    nxt(); chk("s1_c1_busy", 32'(busy_o), 32'd1);           // c1
           chk("s1_c1_halt", 32'(halt_o), 32'd0);
    nxt();                                                 // c2
    nxt(); sync_i = 1'b1; chk("s1_c3_halt", 32'(halt_o), 32'd0);
    nxt(); sync_i = 1'b0;                                  // c4
           chk("s1_c4_halt", 32'(halt_o), 32'd1);
           chk("s1_c4_tcyc", 32'(t_cyc_o), 32'd0);
    nxt(); chk("s1_c5_tstb", 32'(t_stb_o), 32'd0);          // c5
    nxt();                                                 // c6
           chk("s1_c6_tcyc",  32'(t_cyc_o), 32'h04);
           chk("s1_c6_tstb",  32'(t_stb_o), 32'd1);
           chk("s1_c6_taddr", t_addr_o, 32'h0200_0010);
           chk("s1_c6_twe",   32'(t_we_o), 32'd0);
           t_ack_i = 7'b0001000;                           // foreign ack, must be ignored
    nxt();                                                 // c7
           chk("s1_c7_tcyc", 32'(t_cyc_o), 32'h04);
           chk("s1_c7_ack",  32'(wb_ack_o), 32'd0);
           t_ack_i = 7'b0000100;
    nxt(); t_ack_i = '0; drop();                           // c8
           chk("s1_c8_ack",  32'(wb_ack_o), 32'd1);
           chk("s1_c8_err",  32'(wb_err_o), 32'd0);
           chk("s1_c8_data", wb_data_o, 32'hA5A5_0003);
           chk("s1_c8_tcyc", 32'(t_cyc_o), 32'd0);
           chk("s1_c8_tstb", 32'(t_stb_o), 32'd0);
    nxt(); chk("s1_c9_ack",  32'(wb_ack_o), 32'd0);         // c9
           chk("s1_c9_halt", 32'(halt_o), 32'd1);
    repeat (7) nxt(); chk("s1_c16_halt", 32'(halt_o), 32'd1);
    nxt(); chk("s1_c17_halt", 32'(halt_o), 32'd0);         // c17
           chk("s1_c17_busy", 32'(busy_o), 32'd0);

    // ---- 4: target 5 never acks -> timeout error ----
    t_data_i[32*5 +: 32] = 32'hFFFF_FFFF;
    req(32'h0500_0000, 1'b0, 32'd0);                       // c0
    nxt(); sync_i = 1'b1;                                  // c1
    nxt(); sync_i = 1'b0; chk("s4_c2_halt", 32'(halt_o), 32'd1);
    nxt();                                                 // c3
    nxt(); chk("s4_c4_tcyc", 32'(t_cyc_o), 32'h20);         // c4
    repeat (14) nxt();                                     // c18
           chk("s4_c18_tcyc", 32'(t_cyc_o), 32'h20);
           chk("s4_c18_err",  32'(wb_err_o), 32'd0);
    nxt(); drop();                                         // c19
           chk("s4_c19_err",  32'(wb_err_o), 32'd1);
           chk("s4_c19_ack",  32'(wb_ack_o), 32'd0);
           chk("s4_c19_data", wb_data_o, 32'd0);
           chk("s4_c19_tcyc", 32'(t_cyc_o), 32'd0);
    repeat (8) nxt(); chk("s4_c27_halt", 32'(halt_o), 32'd1);
    nxt(); chk("s4_c28_halt", 32'(halt_o), 32'd0);

    // ---- 2: sync never arrives, write to target 0 ----
    t_data_i[31:0] = 32'h1234_5678;
    req(32'h0000_0040, 1'b1, 32'hDEAD_BEEF);               // c0
    repeat (16) nxt(); chk("s2_c16_halt", 32'(halt_o), 32'd0);
    nxt(); chk("s2_c17_halt", 32'(halt_o), 32'd1);
    nxt(); chk("s2_c18_tcyc", 32'(t_cyc_o), 32'd0);
    nxt();                                                 // c19
           chk("s2_c19_tcyc",  32'(t_cyc_o), 32'h01);
           chk("s2_c19_twe",   32'(t_we_o), 32'd1);
           chk("s2_c19_tdata", t_data_o, 32'hDEAD_BEEF);
           t_ack_i = 7'b0000001;
    nxt(); t_ack_i = '0; drop();                           // c20
           chk("s2_c20_ack",  32'(wb_ack_o), 32'd1);
           chk("s2_c20_data", wb_data_o, 32'd0);
    repeat (8) nxt(); chk("s2_c28_halt", 32'(halt_o), 32'd1);
    nxt(); chk("s2_c29_halt", 32'(halt_o), 32'd0);

    // ---- 3: invalid select 7 ----
    req(32'h0700_0000, 1'b0, 32'd0);                       // c0
    nxt(); nxt(); sync_i = 1'b1;                           // c2
    nxt(); sync_i = 1'b0; chk("s3_c3_halt", 32'(halt_o), 32'd1);
    nxt();                                                 // c4
    nxt();                                                 // c5
           chk("s3_c5_tcyc", 32'(t_cyc_o), 32'd0);
           chk("s3_c5_tstb", 32'(t_stb_o), 32'd0);
           chk("s3_c5_busy", 32'(busy_o), 32'd1);
    nxt(); drop();                                         // c6
           chk("s3_c6_err", 32'(wb_err_o), 32'd1);
           chk("s3_c6_ack", 32'(wb_ack_o), 32'd0);
    nxt(); chk("s3_c7_err", 32'(wb_err_o), 32'd0);
    repeat (7) nxt(); chk("s3_c14_halt", 32'(halt_o), 32'd1);
    nxt(); chk("s3_c15_halt", 32'(halt_o), 32'd0);

    // ---- 5: read target 1, then a write 3 cycles after the ack ----
    t_data_i[32*1 +: 32] = 32'h1111_2222;
    req(32'h0100_0008, 1'b0, 32'd0);                       // c0
    nxt(); sync_i = 1'b1;                                  // c1
    nxt(); sync_i = 1'b0;                                  // c2
    nxt();                                                 // c3
    nxt(); chk("s5_c4_tcyc", 32'(t_cyc_o), 32'h02);         // c4
           t_ack_i = 7'b0000010;
    nxt(); t_ack_i = '0; drop();                           // c5
           chk("s5_c5_ack",  32'(wb_ack_o), 32'd1);
           chk("s5_c5_data", wb_data_o, 32'h1111_2222);
    nxt(); chk("s5_c6_halt", 32'(halt_o), 32'd1);
    nxt();                                                 // c7
    nxt(); req(32'h0600_0004, 1'b1, 32'hCAFE_F00D);        // c8
           chk("s5_c8_halt", 32'(halt_o), 32'd1);
           chk("s5_c8_tstb", 32'(t_stb_o), 32'd0);
    nxt();                                                 // c9
           chk("s5_c9_tstb",  32'(t_stb_o), 32'd1);
           chk("s5_c9_tcyc",  32'(t_cyc_o), 32'h40);
           chk("s5_c9_twe",   32'(t_we_o), 32'd1);
           chk("s5_c9_tdata", t_data_o, 32'hCAFE_F00D);
           chk("s5_c9_halt",  32'(halt_o), 32'd1);
           t_ack_i = 7'b1000000;
    nxt(); t_ack_i = '0; drop();                           // c10
           chk("s5_c10_ack",  32'(wb_ack_o), 32'd1);
           chk("s5_c10_data", wb_data_o, 32'd0);
           chk("s5_c10_halt", 32'(halt_o), 32'd1);
    repeat (9) nxt(); chk("s5_c19_halt", 32'(halt_o), 32'd0);

    // ---- 6a: host drops cyc during SETTLE ----
    req(32'h0400_0000, 1'b0, 32'd0);                       // c0
    nxt(); sync_i = 1'b1;                                  // c1
    nxt(); sync_i = 1'b0; drop();                          // c2
           chk("s6_c2_halt", 32'(halt_o), 32'd1);
    nxt();                                                 // c3
           chk("s6_c3_tcyc", 32'(t_cyc_o), 32'd0);
           chk("s6_c3_tstb", 32'(t_stb_o), 32'd0);
           chk("s6_c3_halt", 32'(halt_o), 32'd1);
    nxt(); nxt(); nxt();                                   // c6
           chk("s6_c6_ack", 32'(wb_ack_o), 32'd0);
           chk("s6_c6_err", 32'(wb_err_o), 32'd0);
    repeat (4) nxt(); chk("s6_c10_halt", 32'(halt_o), 32'd1);
    nxt(); chk("s6_c11_halt", 32'(halt_o), 32'd0);

    // ---- 6b: reset asserted mid-ACCESS ----
    req(32'h0300_0000, 1'b1, 32'h0BAD_CAFE);               // c0
    nxt(); sync_i = 1'b1;                                  // c1
    nxt(); sync_i = 1'b0;                                  // c2
    nxt();                                                 // c3
    nxt(); chk("r_c4_tcyc", 32'(t_cyc_o), 32'h08);          // c4
    nxt(); chk("r_c5_tstb", 32'(t_stb_o), 32'd1);           // c5
           rst_ni = 1'b0;
           #1;
           chk("r_halt",  32'(halt_o),  32'd0);
           chk("r_busy",  32'(busy_o),  32'd0);
           chk("r_tcyc",  32'(t_cyc_o), 32'd0);
           chk("r_tstb",  32'(t_stb_o), 32'd0);
           chk("r_twe",   32'(t_we_o),  32'd0);
           chk("r_taddr", t_addr_o,     32'd0);
           chk("r_tdata", t_data_o,     32'd0);
    drop();
    nxt(); rst_ni = 1'b1;
    nxt(); chk("r_post_busy", 32'(busy_o), 32'd0);
           chk("r_post_ack",  32'(wb_ack_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
